// File: rtl/result_deframer.sv
// Result stream deframer: rebuilds {mode, word_a, word_b} frames from a
// byte-wide strobed input. It checks the header and checksum, aborts on long
// inter-byte gaps, and holds the last good frame on its output registers.
module result_deframer #(
    parameter logic [3:0] HDR_MARK       = 4'hA,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter int         CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [31:0] word_a,
    output logic [31:0] word_b,
    output logic [2:0]  mode,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX_A = 2'd1,
        RX_B = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_sh_a;
    logic [31:0]       r_sh_b;
    logic [2:0]        r_sh_mode;
    logic [7:0]        r_xor;
    logic [1:0]        r_idx;
    logic [CNT_W-1:0]  r_gap;
    logic [31:0]       r_word_a;
    logic [31:0]       r_word_b;
    logic [2:0]        r_mode;
    logic              r_frame_valid;
    logic              r_frame_err;
    logic [1:0]        r_err_code;
    logic              r_busy;

    logic              w_accept;
    logic              w_hdr_ok;
    logic              w_timeout;
    logic              w_commit;
    logic              w_err;
    logic [1:0]        w_err_code_nxt;

    assign w_accept  = ena & in_valid;
    assign w_hdr_ok  = (in_byte[7:4] == HDR_MARK) && (in_byte[3] == 1'b0);
    // The increment that would make the gap count reach TIMEOUT_CYCLES aborts.
    assign w_timeout = ena && !in_valid && (r_state != IDLE) && (r_gap == GAP_LAST);

    // Next-state and pulse/error decisions for the frame FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_commit       = 1'b0;
        w_err          = 1'b0;
        w_err_code_nxt = r_err_code;
        case (r_state)
            IDLE: begin
                if (w_accept && w_hdr_ok) begin
                    if (in_byte[2:0] <= 3'd4) begin
                        w_state_nxt = RX_A;
                    end else begin
                        w_err          = 1'b1;
                        w_err_code_nxt = 2'b11;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RX_A, RX_B: begin
                if (w_accept) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = (r_state == RX_A) ? RX_B : CHK;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = IDLE;
                    w_err          = 1'b1;
                    w_err_code_nxt = 2'b10;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            CHK: begin
                if (w_accept) begin
                    w_state_nxt = IDLE;
                    if (in_byte == r_xor) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err          = 1'b1;
                        w_err_code_nxt = 2'b01;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = IDLE;
                    w_err          = 1'b1;
                    w_err_code_nxt = 2'b10;
                end else begin
                    w_state_nxt = CHK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, shadow datapath, gap counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_sh_a        <= 32'd0;
            r_sh_b        <= 32'd0;
            r_sh_mode     <= 3'd0;
            r_xor         <= 8'd0;
            r_idx         <= 2'd0;
            r_gap         <= '0;
            r_word_a      <= 32'd0;
            r_word_b      <= 32'd0;
            r_mode        <= 3'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_code    <= 2'b00;
            r_busy        <= 1'b0;
        end else begin
            // Pulses last one cycle whatever ena does; decisions already need ena.
            r_frame_valid <= w_commit;
            r_frame_err   <= w_err;
            if (ena) begin
                r_state    <= w_state_nxt;
                r_busy     <= (w_state_nxt != IDLE);
                r_err_code <= w_err_code_nxt;
                if ((w_state_nxt == IDLE) || in_valid) begin
                    r_gap <= '0;
                end else begin
                    r_gap <= r_gap + CNT_W'(1);
                end
                if (in_valid) begin
                    case (r_state)
                        IDLE: begin
                            if (w_state_nxt == RX_A) begin
                                r_sh_mode <= in_byte[2:0];
                                r_xor     <= in_byte;
                                r_idx     <= 2'd0;
                            end
                        end
                        RX_A: begin
                            r_sh_a <= {r_sh_a[23:0], in_byte};
                            r_xor  <= r_xor ^ in_byte;
                            r_idx  <= r_idx + 2'd1;
                        end
                        RX_B: begin
                            r_sh_b <= {r_sh_b[23:0], in_byte};
                            r_xor  <= r_xor ^ in_byte;
                            r_idx  <= r_idx + 2'd1;
                        end
                        default: begin
                        end
                    endcase
                end
                if (w_commit) begin
                    r_word_a <= r_sh_a;
                    r_word_b <= r_sh_b;
                    r_mode   <= r_sh_mode;
                end
            end
        end
    end

    assign word_a      = r_word_a;
    assign word_b      = r_word_b;
    assign mode        = r_mode;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign err_code    = r_err_code;
    assign busy        = r_busy;

endmodule

// File: tb/tb_result_deframer.sv
// Bench for result_deframer: a frame-level model (byte list per frame, gap
// count) is stepped every cycle and compared with the DUT, plus literal checks.
module tb_result_deframer;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [2:0]  mode;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    result_deframer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_byte(in_byte), .in_valid(in_valid),
        .word_a(word_a), .word_b(word_b), .mode(mode), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic       s_rst, s_ena, s_v, s_tick;
    logic [7:0] s_b;
    initial s_tick = 1'b0;
    always @(posedge clk) begin
        s_rst  <= rst_n;
        s_ena  <= ena;
        s_v    <= in_valid;
        s_b    <= in_byte;
        s_tick <= 1'b1;
    end

    // Behavioural model state
    logic [7:0]  m_q[$];
    bit          m_in = 1'b0;
    int          m_gap = 0;
    logic [31:0] m_a = 32'd0, m_bw = 32'd0;
    logic [2:0]  m_mode = 3'd0;
    logic        m_fv = 1'b0, m_fe = 1'b0, m_busy = 1'b0;
    logic [1:0]  m_code = 2'd0;

    // Model step after each edge, then compare the whole output set.
    initial begin
        logic [7:0] x;
        forever begin
            @(negedge clk);
            if (s_tick) begin
                if (!s_rst) begin
                    m_q.delete(); m_in = 1'b0; m_gap = 0;
                    m_a = 32'd0; m_bw = 32'd0; m_mode = 3'd0;
                    m_fv = 1'b0; m_fe = 1'b0; m_code = 2'd0;
                end else begin
                    m_fv = 1'b0;
                    m_fe = 1'b0;
                    if (s_ena) begin
                        if (s_v) begin
                            if (!m_in) begin
                                if (s_b[7:4] == 4'hA && s_b[3] == 1'b0) begin
                                    if (s_b[2:0] <= 3'd4) begin
                                        m_in = 1'b1; m_q.delete(); m_q.push_back(s_b); m_gap = 0;
                                    end else begin
                                        m_fe = 1'b1; m_code = 2'd3;
                                    end
                                end
                            end else begin
                                m_q.push_back(s_b);
                                m_gap = 0;
                                if (m_q.size() == 10) begin
                                    x = 8'd0;
                                    for (int i = 0; i < 9; i++) x = x ^ m_q[i];
                                    if (x == m_q[9]) begin
                                        m_a    = {m_q[1], m_q[2], m_q[3], m_q[4]};
                                        m_bw   = {m_q[5], m_q[6], m_q[7], m_q[8]};
                                        m_mode = m_q[0][2:0];
                                        m_fv   = 1'b1;
                                    end else begin
                                        m_fe = 1'b1; m_code = 2'd1;
                                    end
                                    m_in = 1'b0;
                                    m_q.delete();
                                end
                            end
                        end else if (m_in) begin
                            m_gap++;
                            if (m_gap == TMO) begin
                                m_fe = 1'b1; m_code = 2'd2; m_in = 1'b0; m_q.delete();
                            end
                        end
                    end
                end
                m_busy = m_in;
                check("model_cmp",
                      {frame_valid, frame_err, err_code, busy, mode, word_a, word_b, 8'd0},
                      {m_fv, m_fe, m_code, m_busy, m_mode, m_a, m_bw, 8'd0});
            end
        end
    end

    logic [7:0] fr[10];

    task automatic build(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
        logic [7:0] x;
        fr[0] = {4'hA, 1'b0, md};
        for (int i = 0; i < 4; i++) begin
            fr[1+i] = a[31-8*i -: 8];
            fr[5+i] = b[31-8*i -: 8];
        end
        x = 8'd0;
        for (int i = 0; i < 9; i++) x = x ^ fr[i];
        fr[9] = x;
    endtask

    task automatic cyc(input logic e, input logic v, input logic [7:0] b);
        @(negedge clk);
        ena = e; in_valid = v; in_byte = b;
    endtask

    // Send fr[lo..hi]; maxgap>0 inserts random idle/disabled cycles before each byte.
    task automatic send(input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int k = 0; k < g; k++) begin
                if ($urandom_range(0, 1) == 0) cyc(1'b1, 1'b0, 8'($urandom));
                else cyc(1'b0, 1'($urandom), 8'($urandom));
            end
            cyc(1'b1, 1'b1, fr[i]);
        end
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0);
        rst_n = 1'b1;
        check("reset_state", {frame_valid, frame_err, err_code, busy, mode, word_a, word_b, 8'd0}, 80'd0);

        // Good frame from the test plan
        build(3'd3, 32'h12345678, 32'h0000FFFF);
        check("cksum_lit", {72'd0, fr[9]}, {72'd0, 8'hAB});
        send(0, 9, 0);
        cyc(1'b1, 1'b0, 8'd0);
        check("good_fv", {79'd0, frame_valid}, 80'd1);
        check("good_words", {13'd0, mode, word_a, word_b}, {13'd0, 3'd3, 32'h12345678, 32'h0000FFFF});
        check("good_err_busy", {78'd0, frame_err, busy}, 80'd0);

        // Bad checksum
        fr[9] = 8'hAA;
        send(0, 9, 0);
        cyc(1'b1, 1'b0, 8'd0);
        check("badck_err", {76'd0, frame_valid, frame_err, err_code}, {76'd0, 1'b0, 1'b1, 2'b01});
        check("badck_hold", {13'd0, mode, word_a, word_b}, {13'd0, 3'd3, 32'h12345678, 32'h0000FFFF});

        // Timeout after 255 idle cycles, none after 254
        build(3'd3, 32'h12345678, 32'h0000FFFF);
        send(0, 1, 0);
        for (int i = 0; i < TMO; i++) cyc(1'b1, 1'b0, 8'd0);
        check("tmo_pre", {78'd0, frame_err, busy}, {78'd0, 1'b0, 1'b1});
        cyc(1'b1, 1'b0, 8'd0);
        check("tmo_err", {77'd0, frame_err, err_code}, {77'd0, 1'b1, 2'b10});
        check("tmo_idle", {79'd0, busy}, 80'd0);
        build(3'd1, 32'hCAFEF00D, 32'h01020304);
        send(0, 1, 0);
        for (int i = 0; i < TMO - 1; i++) cyc(1'b1, 1'b0, 8'd0);
        send(2, 9, 0);
        cyc(1'b1, 1'b0, 8'd0);
        check("gap254_fv", {79'd0, frame_valid}, 80'd1);
        check("gap254_words", {13'd0, mode, word_a, word_b}, {13'd0, 3'd1, 32'hCAFEF00D, 32'h01020304});

        // Resync and reserved mode
        cyc(1'b1, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 8'h5F);
        cyc(1'b1, 1'b1, 8'hB1);
        cyc(1'b1, 1'b1, 8'hA6);
        check("junk_busy", {78'd0, frame_err, busy}, 80'd0);
        cyc(1'b1, 1'b0, 8'd0);
        check("resv_err", {76'd0, frame_err, busy, err_code}, {76'd0, 1'b1, 1'b0, 2'b11});
        build(3'd4, 32'h89ABCDEF, 32'h76543210);
        send(0, 9, 0);
        cyc(1'b1, 1'b0, 8'd0);
        check("resync_fv", {79'd0, frame_valid}, 80'd1);

        // ena gating for 500 cycles mid-frame
        build(3'd2, 32'hDEADBEEF, 32'h00A5A5A5);
        send(0, 4, 0);
        for (int i = 0; i < 500; i++) cyc(1'b0, 1'(i % 2), 8'($urandom));
        check("ena_hold", {78'd0, frame_err, busy}, {78'd0, 1'b0, 1'b1});
        send(5, 9, 0);
        cyc(1'b1, 1'b0, 8'd0);
        check("ena_words", {12'd0, frame_valid, mode, word_a, word_b}, {12'd0, 1'b1, 3'd2, 32'hDEADBEEF, 32'h00A5A5A5});

        // Back-to-back frames, then reset mid-frame
        build(3'd0, 32'h11111111, 32'h22222222);
        send(0, 9, 0);
        build(3'd1, 32'h33333333, 32'h44444444);
        send(0, 0, 0);
        check("b2b_first", {79'd0, frame_valid}, 80'd1);
        send(1, 9, 0);
        cyc(1'b1, 1'b0, 8'd0);
        check("b2b_second", {12'd0, frame_valid, mode, word_a, word_b}, {12'd0, 1'b1, 3'd1, 32'h33333333, 32'h44444444});
        send(0, 5, 0);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, fr[6]);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'd0);
        check("midrst", {frame_valid, frame_err, err_code, busy, mode, word_a, word_b, 8'd0}, 80'd0);

        // Random frames: random modes, corruption, gaps, ena drops, junk
        for (int f = 0; f < 60; f++) begin
            build(3'($urandom_range(0, 7)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) fr[9] = fr[9] ^ 8'(1 << $urandom_range(0, 7));
            send(0, 9, $urandom_range(0, 1) * 3);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        cyc(1'b1, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
